// File: rtl/inst_cache.sv
// Direct-mapped blocking instruction cache with whole-line refill.
// Serves the PC register's fetch address; hits are combinational.
module inst_cache #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] PcIn,
  input  logic                  FlushReq,
  output logic                  CacheFull,
  output logic                  CacheMissing,
  output logic [INST_WIDTH-1:0] InstOut,
  output logic                  MemReqValid,
  input  logic                  MemReqReady,
  output logic [ADDR_WIDTH-1:0] MemReqAddr,
  input  logic                  MemRespValid,
  input  logic [INST_WIDTH-1:0] MemRespData
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = IDX_W + OFF_W + 2;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } state_t;

  state_t state, stateNext;

  logic [OFF_W-1:0] pcOff;
  logic [IDX_W-1:0] pcIdx;
  logic [TAG_W-1:0] pcTag;
  logic             unusedBits;

  assign pcOff      = PcIn[OFF_W+1:2];
  assign pcIdx      = PcIn[TAG_LSB-1:OFF_W+2];
  assign pcTag      = PcIn[ADDR_WIDTH-1:TAG_LSB];
  assign unusedBits = ^PcIn[1:0];

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tagMem  [SETS];
  logic [INST_WIDTH-1:0] dataMem [SETS][LINE_WORDS];

  logic [IDX_W-1:0]      lineIdx;
  logic [TAG_W-1:0]      lineTag;
  logic [OFF_W-1:0]      cnt;
  logic                  flushPend;
  logic [ADDR_WIDTH-1:0] reqAddr;

  logic hit;
  logic missStart;
  logic beat;
  logic lastBeat;

  assign hit       = valid[pcIdx] && (tagMem[pcIdx] == pcTag);
  assign missStart = !Rst && (state == IDLE) && !hit;
  assign beat      = !Rst && (state == REFILL) && MemRespValid;
  assign lastBeat  = cnt == OFF_W'(LINE_WORDS - 1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext    = state;
    CacheFull    = 1'b0;
    CacheMissing = 1'b0;
    InstOut      = '0;
    MemReqValid  = 1'b0;
    MemReqAddr   = '0;
    if (!Rst) begin
      MemReqAddr = reqAddr;
      unique case (state)
        IDLE: begin
          if (hit) begin
            CacheFull = 1'b1;
            InstOut   = dataMem[pcIdx][pcOff];
          end else begin
            CacheMissing = 1'b1;
            stateNext    = REQ;
          end
        end
        REQ: begin
          CacheMissing = 1'b1;
          MemReqValid  = 1'b1;
          if (MemReqReady) begin
            stateNext = REFILL;
          end
        end
        REFILL: begin
          CacheMissing = 1'b1;
          if (MemRespValid && lastBeat) begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Later assignments deliberately override the blanket flush clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid     <= '0;
      flushPend <= 1'b0;
      reqAddr   <= '0;
      cnt       <= '0;
      lineIdx   <= '0;
      lineTag   <= '0;
    end else begin
      if (FlushReq) begin
        valid <= '0;
        if (state != IDLE) begin
          flushPend <= 1'b1;
        end
      end
      if (missStart) begin
        reqAddr        <= {pcTag, pcIdx, {(OFF_W + 2){1'b0}}};
        lineIdx        <= pcIdx;
        lineTag        <= pcTag;
        cnt            <= '0;
        valid[pcIdx]   <= 1'b0;
      end
      if (beat) begin
        cnt <= cnt + 1'b1;
        if (lastBeat) begin
          valid[lineIdx] <= !(flushPend || FlushReq);
          flushPend      <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (beat) begin
      dataMem[lineIdx][cnt] <= MemRespData;
      if (lastBeat) begin
        tagMem[lineIdx] <= lineTag;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed scenarios then random fetches,
// checked against a per-line array model of the cache contents.
module tb_inst_cache;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [63:0] PcIn;
  logic        FlushReq;
  logic        CacheFull;
  logic        CacheMissing;
  logic [31:0] InstOut;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [63:0] MemReqAddr;
  logic        MemRespValid;
  logic [31:0] MemRespData;

  int checks = 0;
  int errors = 0;

  bit          refValid [16];
  logic [55:0] refTag   [16];
  logic [31:0] refData  [16][4];

  inst_cache dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .PcIn        (PcIn),
    .FlushReq    (FlushReq),
    .CacheFull   (CacheFull),
    .CacheMissing(CacheMissing),
    .InstOut     (InstOut),
    .MemReqValid (MemReqValid),
    .MemReqReady (MemReqReady),
    .MemReqAddr  (MemReqAddr),
    .MemRespValid(MemRespValid),
    .MemRespData (MemRespData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
  endtask

  // mode 0: back-to-back beats, 1: 1,0,1,0,1,1 pattern, 2: random gaps
  task automatic access(input logic [63:0] pc, input bit flushIdle,
                        input int delay, input int mode,
                        input logic [31:0] d0, input int flushCyc,
                        input int jumpCyc, input logic [63:0] jumpPc);
    logic [3:0]  idx;
    logic [1:0]  off;
    logic [55:0] tag;
    logic [31:0] beats [4];
    bit          pend;
    bit          v;
    int          done;
    int          cyc;
    idx = pc[7:4];
    off = pc[3:2];
    tag = pc[63:8];
    PcIn         = pc;
    FlushReq     = flushIdle;
    MemRespValid = 1'($urandom_range(0, 1));
    MemRespData  = $urandom;
    @(negedge Clk);
    if (refValid[idx] && refTag[idx] == tag) begin
      chk("hitFull", 64'(CacheFull), 64'd1);
      chk("hitMissing", 64'(CacheMissing), 64'd0);
      chk("hitInst", 64'(InstOut), 64'(refData[idx][off]));
      chk("hitReqValid", 64'(MemReqValid), 64'd0);
      @(posedge Clk); #1;
      FlushReq = 1'b0;
      if (flushIdle) clearModel();
      return;
    end
    chk("missFull", 64'(CacheFull), 64'd0);
    chk("missMissing", 64'(CacheMissing), 64'd1);
    chk("missInst", 64'(InstOut), 64'd0);
    chk("missReqValid", 64'(MemReqValid), 64'd0);
    @(posedge Clk); #1;
    FlushReq = 1'b0;
    if (flushIdle) clearModel();
    refValid[idx] = 1'b0;
    for (int r = 0; r <= delay; r++) begin
      MemReqReady  = (r == delay);
      MemRespValid = 1'b1;
      MemRespData  = $urandom;
      @(negedge Clk);
      chk("reqValid", 64'(MemReqValid), 64'd1);
      chk("reqAddr", MemReqAddr, {pc[63:4], 4'b0});
      chk("reqMissing", 64'(CacheMissing), 64'd1);
      chk("reqFull", 64'(CacheFull), 64'd0);
      @(posedge Clk); #1;
    end
    MemReqReady = 1'b0;
    for (int k = 0; k < 4; k++)
      beats[k] = (d0 != 0) ? d0 * 32'(k + 1) : $urandom;
    pend = 1'b0;
    done = 0;
    cyc  = 0;
    while (done < 4) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0) || (cyc >= 4);
        default: v = (cyc >= 16) || ($urandom_range(0, 1) == 1);
      endcase
      MemRespValid = v;
      MemRespData  = v ? beats[done] : $urandom;
      FlushReq     = (cyc == flushCyc);
      if (cyc == jumpCyc) PcIn = jumpPc;
      @(negedge Clk);
      chk("fillMissing", 64'(CacheMissing), 64'd1);
      chk("fillFull", 64'(CacheFull), 64'd0);
      chk("fillInst", 64'(InstOut), 64'd0);
      chk("fillReqValid", 64'(MemReqValid), 64'd0);
      if (FlushReq) begin
        clearModel();
        pend = 1'b1;
      end
      @(posedge Clk); #1;
      if (v) done++;
      cyc++;
    end
    MemRespValid  = 1'b0;
    FlushReq      = 1'b0;
    refData[idx]  = beats;
    refTag[idx]   = tag;
    refValid[idx] = !pend;
  endtask

  task automatic fetch(input logic [63:0] pc);
    access(pc, 1'b0, 0, 2, 32'h0, -1, -1, 64'h0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [63:0] jp;
    clearModel();
    Rst          = 1'b1;
    PcIn         = 64'h8000_0000;
    FlushReq     = 1'b0;
    MemReqReady  = 1'b1;
    MemRespValid = 1'b1;
    MemRespData  = 32'hdead_beef;
    repeat (2) begin
      @(negedge Clk);
      chk("rstFull", 64'(CacheFull), 64'd0);
      chk("rstMissing", 64'(CacheMissing), 64'd0);
      chk("rstInst", 64'(InstOut), 64'd0);
      chk("rstReqValid", 64'(MemReqValid), 64'd0);
      chk("rstReqAddr", MemReqAddr, 64'd0);
    end
    @(posedge Clk); #1;
    Rst          = 1'b0;
    MemReqReady  = 1'b0;
    MemRespValid = 1'b0;

    access(64'h8000_0000, 1'b0, 2, 0, 32'h11, -1, -1, 64'h0);
    fetch(64'h8000_0000);
    fetch(64'h8000_0004);
    fetch(64'h8000_0008);
    fetch(64'h8000_000C);

    access(64'h8000_0010, 1'b0, 0, 1, 32'h0, -1, -1, 64'h0);
    fetch(64'h8000_0014);
    fetch(64'h8000_001C);

    fetch(64'h8000_0100);
    fetch(64'h8000_0104);
    fetch(64'h8000_0000);
    fetch(64'h8000_0008);

    fetch(64'h8000_0100);
    access(64'h8000_0000, 1'b0, 1, 0, 32'h0, 1, 2, 64'h8000_0040);
    fetch(64'h8000_0040);
    fetch(64'h8000_0004);

    access(64'h8000_0200, 1'b0, 0, 2, 32'h0, 1, -1, 64'h0);
    fetch(64'h8000_0200);
    fetch(64'h8000_0040);
    access(64'h8000_0300, 1'b0, 0, 0, 32'h0, 3, -1, 64'h0);
    fetch(64'h8000_0300);
    fetch(64'h8000_0304);
    access(64'h8000_0304, 1'b1, 0, 0, 32'h0, -1, -1, 64'h0);
    fetch(64'h8000_0304);

    for (int n = 0; n < 200; n++) begin
      pc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 3) == 0) pc[40] = 1'b1;
      jp = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      access(pc, $urandom_range(0, 15) == 0, $urandom_range(0, 3), 2,
             32'h0,
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1,
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1,
             jp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
